// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
// State encoding is visible on the top-level state port, so values are fixed.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int LOST_CNT_W              = 8;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency 2 clk cycles; no flow control.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock wait with retry/timeout, lock stabilization and
// system reset release; all outputs are registered, pll_locked is seen 2 cycles late.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  clear_fail,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  fail,
  output logic [LOST_CNT_W-1:0] lock_lost_count,
  output logic [2:0]            state
);

  localparam int RST_W = cnt_width(PLL_RST_CYCLES);
  localparam int TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int TRY_W = cnt_width(MAX_RETRIES);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_RETRIES - 1);
  localparam logic [LOST_CNT_W-1:0] LOST_MAX = '1;

  logic locked_s;

  pll_state_e            state_q,   state_d;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0]      timer_q,   timer_d;
  logic [STB_W-1:0]      stable_q,  stable_d;
  logic [TRY_W-1:0]      retry_q,   retry_d;
  logic [LOST_CNT_W-1:0] lost_q,    lost_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_rst_q, sys_rst_d;
  logic                  fail_q,    fail_d;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PLL_RESET;
      rst_cnt_q <= '0;
      timer_q   <= '0;
      stable_q  <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      timer_q   <= timer_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    timer_d   = timer_q;
    stable_d  = stable_q;
    retry_d   = retry_q;
    lost_d    = lost_q;

    case (state_q)
      ST_PLL_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ST_WAIT_LOCK;
          rst_cnt_d = '0;
          timer_d   = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      // A lock seen on the timeout cycle is taken rather than retried.
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d  = ST_STABILIZE;
          stable_d = '0;
        end else if (timer_q == TMO_LAST) begin
          timer_d = '0;
          if (retry_q == TRY_LAST) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + TRY_W'(1);
            state_d = ST_PLL_RESET;
          end
        end else begin
          timer_d = timer_q + TMO_W'(1);
        end
      end

      // A drop always restarts the lock wait, even on the final stable cycle.
      ST_STABILIZE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (stable_q == STB_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else begin
          stable_d = stable_q + STB_W'(1);
        end
      end

      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_PLL_RESET;
          if (lost_q != LOST_MAX) begin
            lost_d = lost_q + LOST_CNT_W'(1);
          end
        end
      end

      ST_FAIL: begin
        if (clear_fail) begin
          state_d = ST_PLL_RESET;
          retry_d = '0;
        end
      end

      default: begin
        state_d = ST_PLL_RESET;
      end
    endcase

    // Output flops follow the next state so they line up with state_q.
    pll_rst_d = (state_d == ST_PLL_RESET);
    sys_rst_d = (state_d != ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign fail            = fail_q;
  assign lock_lost_count = lost_q;
  assign state           = state_q;

endmodule
